// File: rtl/apb_slave_mem_if.sv
// APB4 bus bundle between the slave memory and whoever drives it.
// Ports (signals):
//   psel, penable, pwrite  - select, access qualifier, direction (master -> slave)
//   paddr [ADDR_WIDTH]     - word address (master -> slave)
//   pwdata[DATA_WIDTH]     - write data (master -> slave)
//   pstrb [DATA_WIDTH/8]   - write byte-lane strobes (master -> slave)
//   prdata[DATA_WIDTH]     - read data (slave -> master)
//   pready, pslverr        - completion and error response (slave -> master)
interface apb_slave_mem_if #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32
);
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [ADDR_WIDTH-1:0] paddr;
  logic [DATA_WIDTH-1:0] pwdata;
  logic [STRB_WIDTH-1:0] pstrb;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pready;
  logic                  pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata, pstrb,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata, pstrb,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_slave_mem.sv
// APB4 slave backed by a byte-strobed word memory.
// A transfer is latched on its SETUP edge; pready/pslverr/prdata are all
// registered. Addresses at or beyond MEM_DEPTH complete with pslverr=1,
// suppress writes and return zero read data.
// Optional feature macro: APB_SLV_WAIT_EN -- when defined, every transfer
// holds pready low for WAIT_STATES ACCESS cycles; when undefined, every
// transfer is zero-wait and no wait counter exists.
// Ports:
//   pclk    - bus clock, rising-edge sampling
//   presetn - asynchronous active-low reset (clears memory too)
//   bus     - apb_slave_mem_if.slave (psel/penable/pwrite/paddr/pwdata/pstrb in,
//             prdata/pready/pslverr out)
module apb_slave_mem #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned MEM_DEPTH   = 200,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic           pclk,
  input  logic           presetn,
  apb_slave_mem_if.slave bus
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned IDX_WIDTH  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(MEM_DEPTH);

`ifdef APB_SLV_WAIT_EN
  localparam int unsigned WAITS = WAIT_STATES;
  localparam int unsigned CNT_W = (WAITS > 0) ? $clog2(WAITS + 1) : 1;
`else
  // Wait states compiled out: every transfer completes in its first ACCESS cycle.
  localparam int unsigned WAITS = WAIT_STATES * 0;
`endif

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;

  state_e                state_q,   state_d;
  logic [ADDR_WIDTH-1:0] addr_q,    addr_d;
  logic                  write_q,   write_d;
  logic [DATA_WIDTH-1:0] wdata_q,   wdata_d;
  logic [STRB_WIDTH-1:0] strb_q,    strb_d;
  logic                  pready_q,  pready_d;
  logic                  pslverr_q, pslverr_d;
  logic [DATA_WIDTH-1:0] prdata_q,  prdata_d;
`ifdef APB_SLV_WAIT_EN
  logic [CNT_W-1:0]      cnt_q,     cnt_d;
`endif

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic                  set_resp_c;
  logic                  mem_we_c;
  logic [ADDR_WIDTH-1:0] resp_addr_c;
  logic                  resp_write_c;
  logic                  resp_hit_c;
  logic [DATA_WIDTH-1:0] resp_word_c;

  // Response target: live bus fields on the SETUP edge (zero-wait), latched copies afterwards.
  assign resp_addr_c  = (state_q == IDLE) ? bus.paddr  : addr_q;
  assign resp_write_c = (state_q == IDLE) ? bus.pwrite : write_q;
  assign resp_hit_c   = ({1'b0, resp_addr_c} < DEPTH_L);
  assign resp_word_c  = resp_hit_c ? mem[IDX_WIDTH'(resp_addr_c)] : '0;

  // State and response registers.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      strb_q    <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
`ifdef APB_SLV_WAIT_EN
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      write_q   <= write_d;
      wdata_q   <= wdata_d;
      strb_q    <= strb_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
`ifdef APB_SLV_WAIT_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

  // Next-state, latch capture and response generation.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    write_d    = write_q;
    wdata_d    = wdata_q;
    strb_d     = strb_q;
    pready_d   = pready_q;
    pslverr_d  = pslverr_q;
    prdata_d   = prdata_q;
    set_resp_c = 1'b0;
    mem_we_c   = 1'b0;
`ifdef APB_SLV_WAIT_EN
    cnt_d      = cnt_q;
`endif

    case (state_q)
      IDLE: begin
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        // penable without a preceding SETUP is ignored.
        if (bus.psel && !bus.penable) begin
          state_d = ACCESS;
          addr_d  = bus.paddr;
          write_d = bus.pwrite;
          wdata_d = bus.pwdata;
          strb_d  = bus.pstrb;
          if (WAITS == 0) begin
            set_resp_c = 1'b1;
          end
`ifdef APB_SLV_WAIT_EN
          else begin
            cnt_d = CNT_W'(WAITS);
          end
`endif
        end
      end

      ACCESS: begin
        if (!bus.psel) begin
          // Abort: drop the transfer, prdata keeps its last value.
          state_d   = IDLE;
          pready_d  = 1'b0;
          pslverr_d = 1'b0;
`ifdef APB_SLV_WAIT_EN
          cnt_d     = '0;
`endif
        end else if (pready_q) begin
          if (bus.penable) begin
            state_d   = IDLE;
            pready_d  = 1'b0;
            pslverr_d = 1'b0;
            mem_we_c  = write_q && resp_hit_c;
          end
        end
`ifdef APB_SLV_WAIT_EN
        else begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            set_resp_c = 1'b1;
          end
        end
`endif
      end

      default: state_d = IDLE;
    endcase

    // pready, pslverr and read data are launched together.
    if (set_resp_c) begin
      pready_d  = 1'b1;
      pslverr_d = !resp_hit_c;
      if (!resp_write_c) begin
        prdata_d = resp_word_c;
      end
    end
  end

  // Memory array: cleared on reset, byte-lane write on the completion edge.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      for (int i = 0; i < int'(MEM_DEPTH); i++) begin
        mem[IDX_WIDTH'(i)] <= '0;
      end
    end else if (mem_we_c) begin
      for (int b = 0; b < int'(STRB_WIDTH); b++) begin
        if (strb_q[b]) begin
          mem[IDX_WIDTH'(addr_q)][b*8 +: 8] <= wdata_q[b*8 +: 8];
        end
      end
    end
  end

  assign bus.prdata  = prdata_q;
  assign bus.pready  = pready_q;
  assign bus.pslverr = pslverr_q;

endmodule

// File: tb/tb_apb_slave_mem.sv
// Bench for apb_slave_mem: a transaction-level model (word array + latency
// rule "response in ACCESS cycle W+1") sets the expected outputs for every
// cycle; a single compare process checks them on each falling edge.
`timescale 1ns/1ps
module tb_apb_slave_mem;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 8;
  localparam int unsigned DEPTH = 200;
  localparam int unsigned WS    = 2;
`ifdef APB_SLV_WAIT_EN
  localparam int W = WS;
`else
  localparam int W = 0;
`endif

  logic pclk    = 1'b0;
  logic presetn = 1'b1;

  apb_slave_mem_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  apb_slave_mem #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .MEM_DEPTH  (DEPTH),
    .WAIT_STATES(WS)
  ) dut (
    .pclk   (pclk),
    .presetn(presetn),
    .bus    (bus)
  );

  always #5 pclk = ~pclk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] mdl_mem [256];
  logic [DW-1:0] mdl_rdata;
  logic          exp_pready;
  logic          exp_pslverr;
  logic [DW-1:0] exp_prdata;
  bit            chk_en = 1'b0;

  logic [DW-1:0] got_rd;
  logic          got_err;

  task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model's expectations.
  always @(negedge pclk) begin
    if (chk_en) begin
      check("pready", DW'(bus.pready), DW'(exp_pready));
      if (exp_pready) check("pslverr", DW'(bus.pslverr), DW'(exp_pslverr));
      check("prdata", bus.prdata, exp_prdata);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic next_cycle();
    @(posedge pclk);
    #1;
  endtask

  task automatic set_exp(input logic rdy, input logic err, input logic [DW-1:0] rd);
    exp_pready  = rdy;
    exp_pslverr = err;
    exp_prdata  = rd;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 256; i++) mdl_mem[i] = '0;
    mdl_rdata = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      next_cycle();
      bus.psel    = 1'b0;
      bus.penable = 1'b0;
      set_exp(1'b0, 1'b0, mdl_rdata);
    end
  endtask

  // One APB transfer; abort_at in 1..W+1 drops psel in that ACCESS cycle.
  task automatic xfer(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic [3:0] s, input int abort_at);
    logic          err;
    logic [DW-1:0] resp;
    bit            done;
    err  = (int'(a) >= int'(DEPTH));
    done = 1'b0;
    next_cycle();
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = wr;
    bus.paddr = a; bus.pwdata = d; bus.pstrb = s;
    set_exp(1'b0, 1'b0, mdl_rdata);
    for (int j = 1; j <= W + 1; j++) begin
      if (!done) begin
        next_cycle();
        // Scrambled inputs during ACCESS must not matter.
        bus.penable = 1'b1;
        bus.paddr   = a ^ 8'h5A;
        bus.pwdata  = ~d;
        bus.pstrb   = ~s;
        if (j == abort_at) bus.psel = 1'b0;
        if (j == W + 1) begin
          resp = wr ? mdl_rdata : (err ? '0 : mdl_mem[a]);
          set_exp(1'b1, err, resp);
        end else begin
          set_exp(1'b0, 1'b0, mdl_rdata);
        end
        @(negedge pclk);
        got_rd  = bus.prdata;
        got_err = bus.pslverr;
        if (j == W + 1 && !wr) mdl_rdata = resp;
        if (j == abort_at) done = 1'b1;
      end
    end
    if (!done && wr && !err) begin
      for (int b = 0; b < 4; b++) if (s[b]) mdl_mem[a][b*8 +: 8] = d[b*8 +: 8];
    end
  endtask

  task automatic wr_x(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] s);
    xfer(1'b1, a, d, s, 0);
  endtask

  task automatic rd_x(input logic [AW-1:0] a);
    xfer(1'b0, a, 32'h0, 4'h0, 0);
  endtask

  initial begin
    bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
    bus.paddr = '0; bus.pwdata = '0; bus.pstrb = '0;
    clear_model();
    set_exp(1'b0, 1'b0, '0);
    #1 presetn = 1'b0;
    #1 chk_en = 1'b1;
    idle(2);
    next_cycle();
    presetn = 1'b1;
    idle(1);

    // Read after reset.
    rd_x(8'h05);
    check("rd05_data", got_rd, 32'h0000_0000);
    check("rd05_err", DW'(got_err), 32'h0);

    // Full then partial-lane write, readback.
    wr_x(8'h10, 32'hDEAD_BEEF, 4'b1111);
    wr_x(8'h10, 32'h0000_1122, 4'b0011);
    rd_x(8'h10);
    check("rd10_merge", got_rd, 32'hDEAD_1122);

    // Write with gap then readback.
    wr_x(8'h20, 32'hA5A5_A5A5, 4'b1111);
    idle(3);
    rd_x(8'h20);
    check("rd20", got_rd, 32'hA5A5_A5A5);

    // Out-of-range accesses and the last valid word.
    wr_x(8'hC7, 32'h0BAD_CAFE, 4'b1111);
    wr_x(8'hC8, 32'h1234_5678, 4'b1111);
    check("wrC8_err", DW'(got_err), 32'h1);
    rd_x(8'hC7);
    check("rdC7", got_rd, 32'h0BAD_CAFE);
    rd_x(8'hC8);
    check("rdC8_err", DW'(got_err), 32'h1);
    check("rdC8_data", got_rd, 32'h0);
    rd_x(8'hC7);
    check("rdC7_again", got_rd, 32'h0BAD_CAFE);
    wr_x(8'hFF, 32'hFFFF_FFFF, 4'b1111);
    check("wrFF_err", DW'(got_err), 32'h1);

    // Abort during the transfer: no write.
    xfer(1'b1, 8'h30, 32'hFFFF_FFFF, 4'b1111, (W > 0) ? 2 : 1);
    idle(1);
    rd_x(8'h30);
    check("rd30_abort", got_rd, 32'h0);

    // Zero strobe write and sparse lanes.
    wr_x(8'h10, 32'h5555_5555, 4'b0000);
    check("wr_nostrb_err", DW'(got_err), 32'h0);
    wr_x(8'h11, 32'h1122_3344, 4'b1010);
    rd_x(8'h10);
    check("rd10_nostrb", got_rd, 32'hDEAD_1122);
    rd_x(8'h11);
    check("rd11_lanes", got_rd, 32'h1100_3300);

    // Stray penable without SETUP is ignored.
    next_cycle();
    bus.psel = 1'b1; bus.penable = 1'b1; bus.pwrite = 1'b1; bus.paddr = 8'h00;
    set_exp(1'b0, 1'b0, mdl_rdata);
    idle(2);

    // Back-to-back and address 0.
    wr_x(8'h00, 32'hCAFE_F00D, 4'b1111);
    rd_x(8'h00);
    check("rd00", got_rd, 32'hCAFE_F00D);
    rd_x(8'h20);
    check("rd20_b2b", got_rd, 32'hA5A5_A5A5);

    // Reset between SETUP and completion.
    next_cycle();
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1;
    bus.paddr = 8'h50; bus.pwdata = 32'h7777_7777; bus.pstrb = 4'hF;
    set_exp(1'b0, 1'b0, mdl_rdata);
    next_cycle();
    presetn = 1'b0;
    bus.psel = 1'b0; bus.penable = 1'b0;
    clear_model();
    set_exp(1'b0, 1'b0, '0);
    idle(2);
    next_cycle();
    presetn = 1'b1;
    idle(1);
    rd_x(8'h50);
    check("rd50_after_rst", got_rd, 32'h0);
    rd_x(8'h10);
    check("rd10_after_rst", got_rd, 32'h0);
    idle(2);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_slave_mem.md
Name: apb_slave_mem

Overview:
APB4 slave with byte-strobed word memory. It is the DUT that the APB slave verification environment drives via its driver/monitor interface. It responds to psel/penable with registered pready/pslverr/prdata, inserts optional wait states, and flags out-of-range addresses. Single clock domain (pclk); no bus master logic.

Parameters:
DATA_WIDTH, 32, data bus width; must be a multiple of 8.
ADDR_WIDTH, 8, paddr width; paddr is a word index, not a byte address.
MEM_DEPTH, 200, number of implemented words; must be <= 2**ADDR_WIDTH.
WAIT_STATES, 2, pready-low ACCESS cycles per transfer (used only with APB_SLV_WAIT_EN).

Ports:
pclk  input  1  bus clock; all sampling on rising edge.
presetn  input  1  asynchronous active-low reset.
psel  input  1  slave select.
penable  input  1  access phase qualifier.
pwrite  input  1  1 = write, 0 = read.
paddr  input  ADDR_WIDTH  word address.
pwdata  input  DATA_WIDTH  write data.
pstrb  input  DATA_WIDTH/8  write byte-lane strobes.
prdata  output  DATA_WIDTH  read data, valid while pready=1 on a read.
pready  output  1  transfer-complete indication (registered).
pslverr  output  1  error response, valid only with pready=1 (registered).

Behaviour:
- Reset (presetn=0, asynchronous): state=IDLE, prdata=0, pready=0, pslverr=0, wait counter=0, all memory words=0. Reset mid-transfer aborts the transfer with no memory update.
- FSM states: IDLE, ACCESS.
- IDLE: on an edge sampling psel=1 and penable=0 (SETUP), latch paddr/pwrite/pwdata/pstrb and go to ACCESS. Zero-wait case: pready<=1 at the same edge. Otherwise: counter<=WAIT_STATES and pready<=0.
- IDLE with penable=1 (no prior setup): ignored; pready stays 0.
- ACCESS with pready=0: if psel=0, abort to IDLE. Otherwise decrement the counter; when the counter reaches 1, set pready<=1 so pready is high in the next cycle.
- Completion edge: ACCESS, pready=1, psel=1, penable=1 sampled.
  - Write: commit byte lanes where pstrb[i]=1.
  - Next state is IDLE; pready<=0 and pslverr<=0.
  - A new SETUP can be sampled on the very next edge, so back-to-back transfers cost 2+wait cycles each.
- ACCESS with psel=0 (abort): go to IDLE, clear pready/pslverr, no write. prdata holds.
- Latency: zero-wait read/write gives pready=1 in the first ACCESS cycle, i.e. 2 cycles from SETUP to completion. With N waits: N+2 cycles.
- Read data: when pready is being set for a read, prdata<=mem[latched addr]. prdata holds its value until the next read response. For an error read, prdata<=0.
- Error: latched addr >= MEM_DEPTH sets pslverr<=1 with the same edge that sets pready. Writes are suppressed; memory is unchanged.
- pstrb=0 on a write: no memory change, no error.
- pstrb on a read: ignored.
- Input values while in ACCESS do not affect the transfer: the latched copies are used. An address change during ACCESS is therefore ignored.

Optional Feature:
APB_SLV_WAIT_EN.
- Defined: each transfer holds pready=0 for WAIT_STATES ACCESS cycles before pready=1. WAIT_STATES=0 behaves as zero-wait.
- Undefined: WAIT_STATES is ignored; every transfer is zero-wait (pready=1 in the first ACCESS cycle). The counter logic is not synthesized.

Test Plan:
- Reset then read addr 0x05 → pready=1 in the first ACCESS cycle (macro off), prdata=0x00000000, pslverr=0.
- Write 0xDEADBEEF to 0x10 with pstrb=4'b1111, then write 0x00001122 with pstrb=4'b0011, then read 0x10 → prdata=0xDEAD1122.
- APB_SLV_WAIT_EN, WAIT_STATES=2: write 0xA5A5A5A5 to 0x20 → pready=0 for exactly 2 ACCESS cycles then 1 for 1 cycle. A readback 4 cycles later returns 0xA5A5A5A5.
- Write 0x12345678 to 0xC8 (=200, out of range) → pready=1 and pslverr=1 in the same cycle. Read 0xC8 → pslverr=1, prdata=0. Read 0xC7 is unaffected.
- Abort: SETUP write 0xFFFFFFFF to 0x30, drop psel during a wait cycle → pready never asserted, and a readback of 0x30 gives 0x00000000.
- Assert presetn=0 between the write SETUP and its completion, release, then read the same address → prdata=0, pready/pslverr were 0 during reset.
